cp0_mmu_timer: RTL and testbench
================================

Name: cp0_mmu_timer

Overview:
- Parametrised coprocessor-0 block: next generation of the CP0 in the core.
- Adds a Compare/timer interrupt, a prescaled Count, a live Random register bounded by Wired, and Config/PRId registers.
- TLB index width scales with TLB_ENTRIES.
- Sits beside the execute/commit stage: MTC0/MFC0 access, exception/ERET commit, TLB instruction support toward the TLB.

Parameters:
TLB_ENTRIES, 16, TLB entry count; power of two, 2..64; IW = log2(TLB_ENTRIES)
COUNT_DIV, 2, core clocks per Count increment; >=1
PRID_VALUE, 32'h00018000, read-only PRId contents
K0_RESET, 3'd3, reset value of Config.K0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hint  in  6  external hardware interrupt lines
raddr  in  8  MFC0 address {rd[4:0], sel[2:0]}
rdata  out  32  MFC0 read data (combinational)
wen  in  1  MTC0 write enable
waddr  in  8  MTC0 address {rd, sel}
wdata  in  32  MTC0 data
exp_en  in  1  exception commit
exp_badvaddr_en  in  1  load BadVAddr on exception
exp_badvaddr  in  32  faulting address
exp_bd  in  1  exception in delay slot
exp_code  in  5  ExcCode
exp_epc  in  32  faulting PC
eret  in  1  ERET commit
tlbr  in  1  TLBR commit
tlbp  in  1  TLBP commit
tlbwr  in  1  TLBWR commit (informational; Random free-runs)
miss_probe  in  1  TLBP miss
matched_index_probe  in  IW  TLBP hit index
cp0_tlb_conf_in  in  86  TLB entry read by TLBR
cp0_tlb_conf_out  out  86  {VPN2[18:0], G, ASID[7:0], Lo0[29:1], Lo1[29:1]}
cp0_index  out  IW  Index[IW-1:0]
cp0_random  out  IW  Random[IW-1:0]
curr_ASID  out  8  EntryHi[7:0]
user_mode  out  1  Status.UM & ~EXL & ~ERL
cp0_kseg0_uncached  out  1  Config.K0 == 2
epc_address  out  32  EPC
allow_interrupt  out  1  Status.IE & ~EXL & ~ERL
interrupt_flag  out  8  Status.IM & Cause.IP
timer_int  out  1  Cause.TI

Behaviour:
- Registers (rd,sel):
  - Index(0,0): [31] P, [IW-1:0].
  - Random(1,0): read-only.
  - EntryLo0(2,0), EntryLo1(3,0): [29:0] writable.
  - Wired(6,0): [IW-1:0].
  - BadVAddr(8,0): read-only.
  - Count(9,0).
  - EntryHi(10,0): [31:13], [7:0].
  - Compare(11,0).
  - Status(12,0): BEV[22] reset 1, IM[15:8], UM[4], ERL[2], EXL[1], IE[0].
  - Cause(13,0): BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[1:0] writable.
  - EPC(14,0).
  - PRId(15,0).
  - Config(16,0): [31]=1, K0[2:0] writable.
  - Unlisted addresses read 0; writes to them are ignored.
- Reset:
  - Count=0, Compare=0, prescaler=0, Cause=0, EntryHi=0, Index=0, Wired=0.
  - Random=TLB_ENTRIES-1.
  - Status=32'h00400004 (BEV=1, ERL=1).
  - K0=K0_RESET.
  - Resulting outputs: timer_int=0, user_mode=0, allow_interrupt=0, interrupt_flag=0.
  - EPC, BadVAddr, EntryLo are not reset.
- Cause.IP[7:2] = {hint[5]|TI, hint[4:0]}, registered each cycle.
- Count:
  - Prescaler counts 0..COUNT_DIV-1 and wraps; Count increments (mod 2^32) on wrap.
  - MTC0 Count loads wdata and clears the prescaler; no increment that cycle.
- Timer:
  - When Count increments to a value equal to Compare, TI<=1 on the same edge.
  - MTC0 Compare clears TI. If the set and the clear coincide, clear wins.
- Random:
  - Decrements every cycle.
  - If Random==Wired or Random==0, next value is TLB_ENTRIES-1.
  - MTC0 Wired writes Wired and sets Random=TLB_ENTRIES-1.
  - Wired >= TLB_ENTRIES-1 holds Random at TLB_ENTRIES-1.
- Exception (exp_en):
  - If EXL==0: EPC<=exp_epc, Cause.BD<=exp_bd. If EXL==1: both are unchanged.
  - Always: EXL<=1, ExcCode<=exp_code.
  - BadVAddr<=exp_badvaddr iff exp_badvaddr_en.
- ERET: clears ERL if set, otherwise clears EXL.
- Same-cycle priority, lowest to highest: MTC0 < tlbr/tlbp < eret < exp_en. The higher source wins on each overlapping field.
- TLBR:
  - EntryHi[31:13]<=in[85:67], EntryHi[7:0]<=in[65:58].
  - EntryLo0<={in[57:29], in[66]}, EntryLo1<={in[28:0], in[66]}.
- TLBP: Index[IW-1:0]<=matched_index_probe, Index[31]<=miss_probe.
- cp0_tlb_conf_out: G = EntryLo0[0] & EntryLo1[0].
- rdata is combinational and reflects pre-edge state: a same-cycle MTC0 is not forwarded.

Test Plan:
- Reset, COUNT_DIV=2 -> Status=32'h00400004, Random=15, Config[2:0]=3, PRId=PRID_VALUE; Count=1 after 2 cycles, 5 after 10 cycles.
- MTC0 Compare=10, Count=0; run -> TI=1 and Cause[15]=1 on the edge Count becomes 10; MTC0 Compare=20 -> TI=0 next cycle.
- MTC0 Wired=12 -> Random sequence 15,14,13,12,15,...; Wired=15 -> Random stays 15.
- exp_en (epc=0x80001000, code=4, bd=1) with EXL=0 -> EPC=0x80001000, Cause[31]=1, Cause[6:2]=4, EXL=1; second exp_en (epc=0x2000) -> EPC unchanged.
- Same cycle MTC0 Status=0x11 and exp_en -> EXL=1 (exception wins), IE=1; then eret with ERL=0 -> EXL=0, allow_interrupt=1.
- tlbp miss=1, idx=7 -> Index=0x80000007; tlbr in={19'h12345, G=1, ASID=8'h5A, ...} -> EntryHi=0x2468A05A, EntryLo0[0]=1, EntryLo1[0]=1.

Source files
------------

// File: rtl/cp0_mmu_timer_if.sv
// MFC0/MTC0 register access bus between the execute/commit stage and CP0.
// The core drives the read address and the write strobe/address/data, and
// CP0 returns combinational read data.
interface cp0_mmu_timer_if;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        wen;
  logic [7:0]  waddr;
  logic [31:0] wdata;

  modport master (output raddr, wen, waddr, wdata, input rdata);
  modport slave  (input raddr, wen, waddr, wdata, output rdata);
endinterface

// File: rtl/cp0_mmu_timer.sv
// Coprocessor-0: exception state, prescaled Count/Compare timer interrupt,
// Wired-bounded Random, and the TLB-facing Index/EntryHi/EntryLo registers.
// Register addresses are {rd[4:0], sel[2:0]}. Same-cycle update priority,
// lowest to highest, is MTC0, TLBR/TLBP, ERET, exception commit. It is
// realised by ordering the non-blocking assignments so the later one wins.
module cp0_mmu_timer #(
  parameter int          TLB_ENTRIES = 16,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VALUE  = 32'h00018000,
  parameter logic [2:0]  K0_RESET    = 3'd3,
  localparam int         IW          = $clog2(TLB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_mmu_timer_if.slave       bus,
  input  logic [5:0]           hint,
  input  logic                 exp_en,
  input  logic                 exp_badvaddr_en,
  input  logic [31:0]          exp_badvaddr,
  input  logic                 exp_bd,
  input  logic [4:0]           exp_code,
  input  logic [31:0]          exp_epc,
  input  logic                 eret,
  input  logic                 tlbr,
  input  logic                 tlbp,
  input  logic                 tlbwr,
  input  logic                 miss_probe,
  input  logic [IW-1:0]        matched_index_probe,
  input  logic [85:0]          cp0_tlb_conf_in,
  output logic [85:0]          cp0_tlb_conf_out,
  output logic [IW-1:0]        cp0_index,
  output logic [IW-1:0]        cp0_random,
  output logic [7:0]           curr_ASID,
  output logic                 user_mode,
  output logic                 cp0_kseg0_uncached,
  output logic [31:0]          epc_address,
  output logic                 allow_interrupt,
  output logic [7:0]           interrupt_flag,
  output logic                 timer_int
);

  localparam logic [7:0] A_INDEX    = 8'h00;
  localparam logic [7:0] A_RANDOM   = 8'h08;
  localparam logic [7:0] A_ENTRYLO0 = 8'h10;
  localparam logic [7:0] A_ENTRYLO1 = 8'h18;
  localparam logic [7:0] A_WIRED    = 8'h30;
  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_ENTRYHI  = 8'h50;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;
  localparam logic [7:0] A_PRID     = 8'h78;
  localparam logic [7:0] A_CONFIG   = 8'h80;

  localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  localparam logic [IW-1:0] RAND_TOP   = IW'(TLB_ENTRIES - 1);

  // Timer state
  logic [31:0]   count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [31:0]   compare_reg;
  logic          ti_reg, ti_next;
  logic          count_wr, compare_wr, count_tick;

  // Random / Wired
  logic [IW-1:0] random_reg, random_next;
  logic [IW-1:0] wired_reg;
  logic          wired_wr;

  // TLB interface registers
  logic          index_p_reg;
  logic [IW-1:0] index_reg;
  logic [18:0]   vpn2_reg;
  logic [7:0]    asid_reg;
  logic [29:0]   lo0_reg, lo1_reg;

  // Status fields
  logic          bev_reg, um_reg, erl_reg, exl_reg, ie_reg;
  logic [7:0]    im_reg;

  // Cause fields
  logic          bd_reg;
  logic [4:0]    exccode_reg;
  logic [1:0]    ip_sw_reg;
  logic [5:0]    ip_hw_reg;

  logic [31:0]   epc_reg, badvaddr_reg;
  logic [2:0]    k0_reg;
  logic [7:0]    ip_all;

  // TLBWR needs no CP0 action: Random free-runs regardless.
  logic          unused_tlbwr;
  assign unused_tlbwr = tlbwr;

  // Count prescaling, timer set/clear decision and Random successor
  always_comb begin
    count_wr    = bus.wen && (bus.waddr == A_COUNT);
    compare_wr  = bus.wen && (bus.waddr == A_COMPARE);
    wired_wr    = bus.wen && (bus.waddr == A_WIRED);
    count_tick  = !count_wr && (presc_reg == PRESC_LAST);
    count_next  = count_reg;
    presc_next  = presc_reg + 1'b1;
    if (count_wr) begin
      count_next = bus.wdata;
      presc_next = '0;
    end else if (count_tick) begin
      count_next = count_reg + 32'd1;
      presc_next = '0;
    end
    // Compare write clears the interrupt even if the match fires this cycle
    ti_next = ti_reg;
    if (compare_wr)
      ti_next = 1'b0;
    else if (count_tick && (count_next == compare_reg))
      ti_next = 1'b1;
    random_next = random_reg - 1'b1;
    if ((random_reg == wired_reg) || (random_reg == '0))
      random_next = RAND_TOP;
  end

  // Count, prescaler, Compare and the timer interrupt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      presc_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      count_reg <= count_next;
      presc_reg <= presc_next;
      ti_reg    <= ti_next;
      if (compare_wr)
        compare_reg <= bus.wdata;
    end
  end

  // Random decrements toward Wired and reloads at the top of the TLB
  always_ff @(posedge clk) begin
    if (rst) begin
      random_reg <= RAND_TOP;
      wired_reg  <= '0;
    end else if (wired_wr) begin
      wired_reg  <= bus.wdata[IW-1:0];
      random_reg <= RAND_TOP;
    end else begin
      random_reg <= random_next;
    end
  end

  // Reset-initialised architectural registers, layered by update priority
  always_ff @(posedge clk) begin
    if (rst) begin
      index_p_reg <= 1'b0;
      index_reg   <= '0;
      vpn2_reg    <= '0;
      asid_reg    <= '0;
      bev_reg     <= 1'b1;
      im_reg      <= '0;
      um_reg      <= 1'b0;
      erl_reg     <= 1'b1;
      exl_reg     <= 1'b0;
      ie_reg      <= 1'b0;
      bd_reg      <= 1'b0;
      exccode_reg <= '0;
      ip_sw_reg   <= '0;
      ip_hw_reg   <= '0;
      k0_reg      <= K0_RESET;
    end else begin
      if (bus.wen) begin
        case (bus.waddr)
          A_INDEX:   index_reg <= bus.wdata[IW-1:0];
          A_ENTRYHI: begin
            vpn2_reg <= bus.wdata[31:13];
            asid_reg <= bus.wdata[7:0];
          end
          A_STATUS:  begin
            bev_reg <= bus.wdata[22];
            im_reg  <= bus.wdata[15:8];
            um_reg  <= bus.wdata[4];
            erl_reg <= bus.wdata[2];
            exl_reg <= bus.wdata[1];
            ie_reg  <= bus.wdata[0];
          end
          A_CAUSE:   ip_sw_reg <= bus.wdata[9:8];
          A_CONFIG:  k0_reg    <= bus.wdata[2:0];
          default:   ;
        endcase
      end
      if (tlbr) begin
        vpn2_reg <= cp0_tlb_conf_in[85:67];
        asid_reg <= cp0_tlb_conf_in[65:58];
      end
      if (tlbp) begin
        index_reg   <= matched_index_probe;
        index_p_reg <= miss_probe;
      end
      if (eret) begin
        if (erl_reg) erl_reg <= 1'b0;
        else         exl_reg <= 1'b0;
      end
      if (exp_en) begin
        if (!exl_reg) bd_reg <= exp_bd;
        exl_reg     <= 1'b1;
        exccode_reg <= exp_code;
      end
      // IP7 follows the timer flag of this same edge so both rise together
      ip_hw_reg <= {hint[5] | ti_next, hint[4:0]};
    end
  end

  // Registers without reset: EntryLo pair, EPC and BadVAddr
  always_ff @(posedge clk) begin
    if (bus.wen) begin
      case (bus.waddr)
        A_ENTRYLO0: lo0_reg <= bus.wdata[29:0];
        A_ENTRYLO1: lo1_reg <= bus.wdata[29:0];
        A_EPC:      epc_reg <= bus.wdata;
        default:    ;
      endcase
    end
    if (tlbr) begin
      lo0_reg <= {cp0_tlb_conf_in[57:29], cp0_tlb_conf_in[66]};
      lo1_reg <= {cp0_tlb_conf_in[28:0],  cp0_tlb_conf_in[66]};
    end
    if (exp_en) begin
      if (!exl_reg)        epc_reg      <= exp_epc;
      if (exp_badvaddr_en) badvaddr_reg <= exp_badvaddr;
    end
  end

  // MFC0 read mux on pre-edge state
  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      A_INDEX:    bus.rdata = {index_p_reg, {(31-IW){1'b0}}, index_reg};
      A_RANDOM:   bus.rdata = {{(32-IW){1'b0}}, random_reg};
      A_ENTRYLO0: bus.rdata = {2'b00, lo0_reg};
      A_ENTRYLO1: bus.rdata = {2'b00, lo1_reg};
      A_WIRED:    bus.rdata = {{(32-IW){1'b0}}, wired_reg};
      A_BADVADDR: bus.rdata = badvaddr_reg;
      A_COUNT:    bus.rdata = count_reg;
      A_ENTRYHI:  bus.rdata = {vpn2_reg, 5'b0, asid_reg};
      A_COMPARE:  bus.rdata = compare_reg;
      A_STATUS:   bus.rdata = {9'b0, bev_reg, 6'b0, im_reg, 3'b0, um_reg,
                               1'b0, erl_reg, exl_reg, ie_reg};
      A_CAUSE:    bus.rdata = {bd_reg, ti_reg, 14'b0, ip_hw_reg, ip_sw_reg,
                               1'b0, exccode_reg, 2'b00};
      A_EPC:      bus.rdata = epc_reg;
      A_PRID:     bus.rdata = PRID_VALUE;
      A_CONFIG:   bus.rdata = {1'b1, 28'b0, k0_reg};
      default:    bus.rdata = '0;
    endcase
  end

  assign ip_all = {ip_hw_reg, ip_sw_reg};

  // Pending-and-enabled interrupt lines, one per IP bit
  for (genvar gi = 0; gi < 8; gi++) begin : g_int_flag
    assign interrupt_flag[gi] = im_reg[gi] & ip_all[gi];
  end

  assign cp0_tlb_conf_out   = {vpn2_reg, lo0_reg[0] & lo1_reg[0], asid_reg,
                               lo0_reg[29:1], lo1_reg[29:1]};
  assign cp0_index          = index_reg;
  assign cp0_random         = random_reg;
  assign curr_ASID          = asid_reg;
  assign user_mode          = um_reg & ~exl_reg & ~erl_reg;
  assign cp0_kseg0_uncached = (k0_reg == 3'd2);
  assign epc_address        = epc_reg;
  assign allow_interrupt    = ie_reg & ~exl_reg & ~erl_reg;
  assign timer_int          = ti_reg;

endmodule

// File: tb/tb_cp0_mmu_timer.sv
// Testbench for cp0_mmu_timer: reset table, directed multi-cycle sequences,
// then randomized traffic checked against a word-level register model.
`timescale 1ns/1ps
module tb_cp0_mmu_timer;
  localparam int          N    = 16;
  localparam int          IW   = 4;
  localparam int          DIV  = 2;
  localparam logic [31:0] PRID = 32'h00018000;

  localparam logic [7:0] A_INDEX = 8'h00, A_RANDOM = 8'h08, A_LO0 = 8'h10,
    A_LO1 = 8'h18, A_WIRED = 8'h30, A_BADV = 8'h40, A_COUNT = 8'h48,
    A_HI = 8'h50, A_COMPARE = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68,
    A_EPC = 8'h70, A_PRID = 8'h78, A_CONFIG = 8'h80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]    raddr, waddr;
  logic [31:0]   wdata, rdata;
  logic          wen;
  logic [5:0]    hw_irq;
  logic          exp_en, exp_badvaddr_en, exp_bd, eret, tlbr, tlbp, tlbwr, miss_probe;
  logic [31:0]   exp_badvaddr, exp_epc;
  logic [4:0]    exp_code;
  logic [IW-1:0] matched_index_probe, cp0_index, cp0_random;
  logic [85:0]   cp0_tlb_conf_in, cp0_tlb_conf_out;
  logic [7:0]    curr_ASID, interrupt_flag;
  logic          user_mode, cp0_kseg0_uncached, allow_interrupt, timer_int;
  logic [31:0]   epc_address;

  cp0_mmu_timer_if bus_if();
  assign bus_if.raddr = raddr;
  assign bus_if.wen   = wen;
  assign bus_if.waddr = waddr;
  assign bus_if.wdata = wdata;
  assign rdata        = bus_if.rdata;

  cp0_mmu_timer #(.TLB_ENTRIES(N), .COUNT_DIV(DIV), .PRID_VALUE(PRID), .K0_RESET(3'd3)) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave), .hint(hw_irq),
    .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_badvaddr(exp_badvaddr),
    .exp_bd(exp_bd), .exp_code(exp_code), .exp_epc(exp_epc), .eret(eret),
    .tlbr(tlbr), .tlbp(tlbp), .tlbwr(tlbwr), .miss_probe(miss_probe),
    .matched_index_probe(matched_index_probe), .cp0_tlb_conf_in(cp0_tlb_conf_in),
    .cp0_tlb_conf_out(cp0_tlb_conf_out), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .curr_ASID(curr_ASID), .user_mode(user_mode), .cp0_kseg0_uncached(cp0_kseg0_uncached),
    .epc_address(epc_address), .allow_interrupt(allow_interrupt),
    .interrupt_flag(interrupt_flag), .timer_int(timer_int));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each register as a whole 32-bit word
  logic [31:0] m_index, m_lo0, m_lo1, m_wired, m_badv, m_count, m_hi, m_compare;
  logic [31:0] m_status, m_cause, m_epc, m_config;
  int          m_random, m_presc;

  typedef struct { logic [7:0] addr; logic [31:0] exp; } rvec_t;
  rvec_t rst_tab[11];
  int    rand_seq[8];
  logic [7:0] addr_list[16];

  function automatic logic [31:0] mw(input logic [31:0] old, input logic [31:0] nw,
                                     input logic [31:0] mask);
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic model_reset();
    m_index = 0; m_lo0 = 0; m_lo1 = 0; m_wired = 0; m_badv = 0; m_count = 0;
    m_hi = 0; m_compare = 0; m_status = 32'h00400004; m_cause = 0; m_epc = 0;
    m_config = 32'h80000003; m_random = N - 1; m_presc = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_INDEX: return m_index;       A_RANDOM: return 32'(m_random);
      A_LO0: return m_lo0;           A_LO1: return m_lo1;
      A_WIRED: return m_wired;       A_BADV: return m_badv;
      A_COUNT: return m_count;       A_HI: return m_hi;
      A_COMPARE: return m_compare;   A_STATUS: return m_status;
      A_CAUSE: return m_cause;       A_EPC: return m_epc;
      A_PRID: return PRID;           A_CONFIG: return m_config;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_update();
    logic [31:0] old_status;
    logic        ti, inc;
    if (rst) begin model_reset(); return; end
    old_status = m_status;
    ti  = m_cause[30];
    inc = 1'b0;
    if (wen && waddr == A_COUNT) begin
      m_count = wdata; m_presc = 0;
    end else begin
      m_presc++;
      if (m_presc == DIV) begin m_presc = 0; m_count = m_count + 1; inc = 1'b1; end
    end
    if (wen && waddr == A_COMPARE) ti = 1'b0;
    else if (inc && m_count == m_compare) ti = 1'b1;
    if (wen && waddr == A_WIRED) m_random = N - 1;
    else if (m_random == int'(m_wired) || m_random == 0) m_random = N - 1;
    else m_random--;
    if (wen) begin
      case (waddr)
        A_INDEX:   m_index   = mw(m_index, wdata, N - 1);
        A_LO0:     m_lo0     = mw(m_lo0, wdata, 32'h3FFFFFFF);
        A_LO1:     m_lo1     = mw(m_lo1, wdata, 32'h3FFFFFFF);
        A_WIRED:   m_wired   = mw(m_wired, wdata, N - 1);
        A_HI:      m_hi      = mw(m_hi, wdata, 32'hFFFFE0FF);
        A_COMPARE: m_compare = wdata;
        A_STATUS:  m_status  = mw(m_status, wdata, 32'h0040FF17);
        A_CAUSE:   m_cause   = mw(m_cause, wdata, 32'h00000300);
        A_EPC:     m_epc     = wdata;
        A_CONFIG:  m_config  = mw(m_config, wdata, 32'h7);
        default: ;
      endcase
    end
    if (tlbr) begin
      m_hi  = {cp0_tlb_conf_in[85:67], 5'b0, cp0_tlb_conf_in[65:58]};
      m_lo0 = {2'b0, cp0_tlb_conf_in[57:29], cp0_tlb_conf_in[66]};
      m_lo1 = {2'b0, cp0_tlb_conf_in[28:0], cp0_tlb_conf_in[66]};
    end
    if (tlbp) m_index = {miss_probe, 27'b0, matched_index_probe};
    if (eret) begin
      if (old_status[2]) m_status[2] = 1'b0;
      else               m_status[1] = 1'b0;
    end
    if (exp_en) begin
      if (!old_status[1]) begin m_epc = exp_epc; m_cause[31] = exp_bd; end
      m_status[1]  = 1'b1;
      m_cause[6:2] = exp_code;
      if (exp_badvaddr_en) m_badv = exp_badvaddr;
    end
    m_cause[30]    = ti;
    m_cause[15:10] = {hw_irq[5] | ti, hw_irq[4:0]};
  endtask

  task automatic chk(input string name, input logic [85:0] act, input logic [85:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    raddr = a;
    #0.2;
    d = rdata;
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
    $display("read %s addr=%h data=%h", name, a, d);
  endtask

  task automatic clear_pulses();
    wen = 0; exp_en = 0; exp_badvaddr_en = 0; eret = 0; tlbr = 0; tlbp = 0; tlbwr = 0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    wen = 1; waddr = a; wdata = d;
    cycle();
    wen = 0;
  endtask

  initial begin
    logic [31:0] d, c;
    logic        found;
    logic [85:0] tin;

    rst_tab[0]  = '{A_STATUS,  32'h00400004};
    rst_tab[1]  = '{A_RANDOM,  32'd15};
    rst_tab[2]  = '{A_CONFIG,  32'h80000003};
    rst_tab[3]  = '{A_PRID,    PRID};
    rst_tab[4]  = '{A_COUNT,   32'd0};
    rst_tab[5]  = '{A_COMPARE, 32'd0};
    rst_tab[6]  = '{A_CAUSE,   32'd0};
    rst_tab[7]  = '{A_HI,      32'd0};
    rst_tab[8]  = '{A_INDEX,   32'd0};
    rst_tab[9]  = '{A_WIRED,   32'd0};
    rst_tab[10] = '{8'hF8,     32'd0};
    rand_seq = '{15, 14, 13, 12, 15, 14, 13, 12};
    addr_list = '{A_INDEX, A_RANDOM, A_LO0, A_LO1, A_WIRED, A_BADV, A_COUNT, A_HI,
                  A_COMPARE, A_STATUS, A_CAUSE, A_EPC, A_PRID, A_CONFIG, 8'h38, 8'h01};

    rst = 1; raddr = 0; waddr = 0; wdata = 0; hw_irq = 0; exp_badvaddr = 0; exp_bd = 0;
    exp_code = 0; exp_epc = 0; miss_probe = 0; matched_index_probe = 0; cp0_tlb_conf_in = 0;
    clear_pulses();
    model_reset();
    @(negedge clk);
    repeat (3) cycle();
    rst = 0;

    // Reset state, read without advancing the clock
    for (int i = 0; i < 11; i++) chk_rd("reset_reg", rst_tab[i].addr, rst_tab[i].exp);
    chk("reset_outputs", {timer_int, user_mode, allow_interrupt, interrupt_flag, cp0_kseg0_uncached},
        86'd0);

    // Prescaled Count
    repeat (2) cycle();
    chk_rd("count_after_2", A_COUNT, 32'd1);
    repeat (8) cycle();
    chk_rd("count_after_10", A_COUNT, 32'd5);

    // Timer match and Compare-write clear
    mtc0(A_COMPARE, 32'd10);
    mtc0(A_COUNT, 32'd0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      rd(A_COUNT, d);
      if (d == 32'd9) chk("ti_before_match", timer_int, 1'b0);
      if (d == 32'd10) begin
        found = 1;
        rd(A_CAUSE, c);
        chk("ti_at_match", timer_int, 1'b1);
        chk("cause_ti_ip7", {c[30], c[15]}, 2'b11);
        $display("timer match count=%0d cause=%h", d, c);
      end
    end
    if (!found) chk("timer_reach_10", 1'b0, 1'b1);
    mtc0(A_COMPARE, 32'd20);
    rd(A_CAUSE, c);
    chk("ti_cleared", {timer_int, c[30], c[15]}, 3'b000);

    // Random bounded by Wired, then held at the top
    mtc0(A_WIRED, 32'd12);
    for (int i = 0; i < 8; i++) begin
      chk_rd("random_wired12", A_RANDOM, 32'(rand_seq[i]));
      cycle();
    end
    mtc0(A_WIRED, 32'd15);
    for (int i = 0; i < 4; i++) begin
      chk_rd("random_hold", A_RANDOM, 32'd15);
      cycle();
    end

    // Exception from EXL=0, then a nested one leaves EPC/BD alone
    exp_en = 1; exp_epc = 32'h80001000; exp_code = 5'd4; exp_bd = 1;
    cycle();
    clear_pulses();
    chk_rd("exc_epc", A_EPC, 32'h80001000);
    rd(A_CAUSE, c);
    chk("exc_bd_code", {c[31], c[6:2]}, {1'b1, 5'd4});
    rd(A_STATUS, d);
    chk("exc_exl", d[1], 1'b1);
    exp_en = 1; exp_epc = 32'h00002000; exp_code = 5'd5; exp_bd = 0;
    cycle();
    clear_pulses();
    chk_rd("nested_epc", A_EPC, 32'h80001000);
    rd(A_CAUSE, c);
    chk("nested_bd_code", {c[31], c[6:2]}, {1'b1, 5'd5});

    // MTC0 Status colliding with exception, then ERET
    wen = 1; waddr = A_STATUS; wdata = 32'h11;
    exp_en = 1; exp_epc = 32'h3000; exp_code = 5'd8;
    cycle();
    clear_pulses();
    rd(A_STATUS, d);
    chk("mtc0_vs_exc", {d[1], d[0], allow_interrupt}, 3'b110);
    eret = 1;
    cycle();
    clear_pulses();
    rd(A_STATUS, d);
    chk("eret_exl", {d[2], d[1], allow_interrupt, user_mode}, 4'b0011);

    // TLBP miss and TLBR load
    tlbp = 1; miss_probe = 1; matched_index_probe = 4'd7;
    cycle();
    clear_pulses();
    chk_rd("tlbp_index", A_INDEX, 32'h80000007);
    tin = {19'h12345, 1'b1, 8'h5A, 29'h1ABCDEF, 29'h0123456};
    cp0_tlb_conf_in = tin; tlbr = 1;
    cycle();
    clear_pulses();
    chk_rd("tlbr_hi", A_HI, 32'h2468A05A);
    chk_rd("tlbr_lo0", A_LO0, {2'b0, 29'h1ABCDEF, 1'b1});
    rd(A_LO1, d);
    chk("tlbr_lo1_g", d[0], 1'b1);
    chk("tlbr_asid", curr_ASID, 8'h5A);
    chk("tlbr_conf_out", cp0_tlb_conf_out, tin);

    // Define the unreset registers before the random phase
    exp_en = 1; exp_badvaddr_en = 1; exp_badvaddr = 32'hBAD0BAD0;
    cycle();
    clear_pulses();
    mtc0(A_EPC, 32'h00001234);

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      clear_pulses();
      hw_irq = 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        wen = 1;
        waddr = addr_list[$urandom_range(0, 15)];
        wdata = $urandom;
        if (waddr == A_COUNT)   wdata = m_compare - 32'($urandom_range(0, 4));
        if (waddr == A_COMPARE && $urandom_range(0, 1) == 1)
          wdata = m_count + 32'($urandom_range(0, 4));
      end
      exp_en = ($urandom_range(0, 11) == 0);
      exp_badvaddr_en = $urandom_range(0, 1);
      exp_badvaddr = $urandom; exp_epc = $urandom; exp_bd = $urandom_range(0, 1);
      exp_code = 5'($urandom);
      eret = ($urandom_range(0, 11) == 0);
      tlbr = ($urandom_range(0, 9) == 0);
      tlbp = ($urandom_range(0, 9) == 0);
      tlbwr = ($urandom_range(0, 9) == 0);
      miss_probe = $urandom_range(0, 1);
      matched_index_probe = 4'($urandom);
      cp0_tlb_conf_in = {$urandom, $urandom, $urandom};
      cycle();
      clear_pulses();
      raddr = addr_list[$urandom_range(0, 15)];
      #0.2;
      chk("rand_rdata", rdata, m_read(raddr));
      chk("rand_outputs",
          {timer_int, user_mode, allow_interrupt, interrupt_flag, cp0_index, cp0_random,
           curr_ASID, cp0_kseg0_uncached},
          {m_cause[30], m_status[4] & ~m_status[1] & ~m_status[2],
           m_status[0] & ~m_status[1] & ~m_status[2], m_status[15:8] & m_cause[15:8],
           m_index[3:0], 4'(m_random), m_hi[7:0], m_config[2:0] == 3'd2});
      chk("rand_epc", epc_address, m_epc);
      chk("rand_conf_out", cp0_tlb_conf_out,
          {m_hi[31:13], m_lo0[0] & m_lo1[0], m_hi[7:0], m_lo0[29:1], m_lo1[29:1]});
      $display("rand %0d addr=%h rdata=%h ti=%0b", t, raddr, rdata, timer_int);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
